// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// Instruction fetch front end.
// Reads the next word from a synchronous instruction ROM, strobes the IR load
// enable for one cycle, and then advances the PC. Absolute PC loads are accepted in IDLE.
module instr_fetch #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RESET_PC     = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  FetchReq,
    input  logic                  PcLoad,
    input  logic [ADDR_WIDTH-1:0] PcLoadVal,
    output logic [ADDR_WIDTH-1:0] RomAddr,
    input  logic [15:0]           RomData,
    output logic [15:0]           IrData,
    output logic                  Id,
    output logic                  FetchDone,
    output logic                  Busy,
    output logic [ADDR_WIDTH-1:0] Pc
);

    // Two bits cover the full legal latency range of 1..4.
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_id;
    logic                    r_busy;

    // State, PC, and latency counter registers. The strobes are registered from the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= ADDR_WIDTH'(RESET_PC);
            r_cnt   <= '0;
            r_id    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= (w_state_nxt == ST_LOAD);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state logic. Requests are honoured only in IDLE, so the PC is stable during a fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                // A PC load and a fetch request in the same cycle both take effect.
                // The fetch therefore reads from the newly loaded target.
                if (PcLoad) begin
                    w_pc_nxt = PcLoadVal;
                end
                if (FetchReq) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(READ_LATENCY - 1)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_pc_nxt    = r_pc + ADDR_WIDTH'(1);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign RomAddr   = r_pc;
    assign Pc        = r_pc;
    assign IrData    = RomData;
    assign Id        = r_id;
    assign FetchDone = r_id;
    assign Busy      = r_busy;

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// Bench for instr_fetch: two instances, with ROM latencies of 1 and 3.
// Both instances are checked against a fetch-age reference model.
module tb_instr_fetch;

    localparam int unsigned AW = 7;

    logic          Clk;
    logic          Reset;
    logic          FetchReq;
    logic          PcLoad;
    logic [AW-1:0] PcLoadVal;

    logic [AW-1:0] addr1, pc1, addr3, pc3;
    logic [15:0]   rom1, ir1, rom3, ir3;
    logic          id1, fd1, busy1, id3, fd3, busy3;
    logic [15:0]   p3 [3];

    instr_fetch #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .RESET_PC(0)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .FetchReq(FetchReq), .PcLoad(PcLoad),
        .PcLoadVal(PcLoadVal), .RomAddr(addr1), .RomData(rom1), .IrData(ir1),
        .Id(id1), .FetchDone(fd1), .Busy(busy1), .Pc(pc1)
    );

    instr_fetch #(.ADDR_WIDTH(AW), .READ_LATENCY(3), .RESET_PC(0)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .FetchReq(FetchReq), .PcLoad(PcLoad),
        .PcLoadVal(PcLoadVal), .RomAddr(addr3), .RomData(rom3), .IrData(ir3),
        .Id(id3), .FetchDone(fd3), .Busy(busy3), .Pc(pc3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // The ROM contents are word[a] = A000 + a. The reads are synchronous, with latency 1 or 3.
    always @(posedge Clk) begin
        rom1  <= 16'hA000 + {9'd0, addr1};
        p3[0] <= 16'hA000 + {9'd0, addr3};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rom3 = p3[2];

    // The model tracks, for each instance, the number of cycles since its fetch was accepted.
    int            n_assert = 0;
    int            n_fail   = 0;
    int            m_age [2];
    logic [AW-1:0] m_pc  [2];
    int            lat   [2];
    logic          collect;
    logic [15:0]   got_q [$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input logic req, input logic ld,
                              input logic [AW-1:0] val, input logic rst);
        if (rst) begin
            m_age[i] = -1;
            m_pc[i]  = '0;
        end else if (m_age[i] < 0) begin
            if (ld)  m_pc[i]  = val;
            if (req) m_age[i] = 0;
        end else if (m_age[i] == lat[i]) begin
            m_age[i] = -1;
            m_pc[i]  = m_pc[i] + AW'(1);
        end else begin
            m_age[i] = m_age[i] + 1;
        end
    endtask

    task automatic check_one(input int i, input logic id, input logic fd, input logic busy,
                             input logic [AW-1:0] pc, input logic [AW-1:0] ra,
                             input logic [15:0] ir);
        logic exp_id;
        exp_id = (m_age[i] == lat[i]);
        chk($sformatf("L%0d.Id", lat[i]), 16'(id), 16'(exp_id));
        chk($sformatf("L%0d.FetchDone", lat[i]), 16'(fd), 16'(exp_id));
        chk($sformatf("L%0d.Busy", lat[i]), 16'(busy), 16'(m_age[i] >= 0));
        chk($sformatf("L%0d.Pc", lat[i]), 16'(pc), 16'(m_pc[i]));
        chk($sformatf("L%0d.RomAddr", lat[i]), 16'(ra), 16'(m_pc[i]));
        if (exp_id) chk($sformatf("L%0d.IrData", lat[i]), ir, 16'hA000 + 16'(m_pc[i]));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, and then check both instances.
    task automatic step(input logic req, input logic ld, input logic [AW-1:0] val, input logic rst);
        FetchReq  = req;
        PcLoad    = ld;
        PcLoadVal = val;
        Reset     = rst;
        @(posedge Clk);
        model_edge(0, req, ld, val, rst);
        model_edge(1, req, ld, val, rst);
        #1;
        check_one(0, id1, fd1, busy1, pc1, addr1, ir1);
        check_one(1, id3, fd3, busy3, pc3, addr3, ir3);
        if (collect && id1) got_q.push_back(ir1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    int id_cnt;
    int busy_cnt;
    int id_at;

    initial begin
        lat[0]    = 1;
        lat[1]    = 3;
        m_age[0]  = -1;
        m_age[1]  = -1;
        m_pc[0]   = '0;
        m_pc[1]   = '0;
        collect   = 1'b0;
        FetchReq  = 1'b0;
        PcLoad    = 1'b0;
        PcLoadVal = '0;
        Reset     = 1'b1;

        // Check the reset state.
        do_reset();
        chk("reset.Pc", 16'(pc1), 16'h0000);
        chk("reset.Busy", 16'(busy1), 16'h0000);

        // Issue a single fetch request pulse.
        step(1'b1, 1'b0, '0, 1'b0);
        chk("single.BusyE0", 16'(busy1), 16'h0001);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("single.IdE1", 16'(id1), 16'h0001);
        chk("single.IrData", ir1, 16'hA000);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("single.PcE2", 16'(pc1), 16'h0001);
        chk("single.BusyE2", 16'(busy1), 16'h0000);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);

        // Hold FetchReq high for three back-to-back fetches.
        do_reset();
        got_q.delete();
        collect = 1'b1;
        repeat (9) step(1'b1, 1'b0, '0, 1'b0);
        collect = 1'b0;
        chk("b2b.count", 16'(got_q.size()), 16'd3);
        for (int k = 0; k < 3 && k < got_q.size(); k++)
            chk($sformatf("b2b.ir%0d", k), got_q[k], 16'hA000 + 16'(k));
        step(1'b0, 1'b0, '0, 1'b0);
        chk("b2b.Pc", 16'(pc1), 16'h0003);
        repeat (5) step(1'b0, 1'b0, '0, 1'b0);

        // Apply a PC load and a fetch in the same cycle at the top address, which wraps the PC.
        do_reset();
        step(1'b1, 1'b1, 7'h7F, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("wrap.Id", 16'(id1), 16'h0001);
        chk("wrap.IrData", ir1, 16'hA07F);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("wrap.Pc", 16'(pc1), 16'h0000);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);

        // Assert PcLoad during WAIT, where it is ignored. A later PcLoad in IDLE is applied.
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        repeat (6) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 7'h10, 1'b0);
        chk("ldwait.Id", 16'(id1), 16'h0001);
        chk("ldwait.IrData", ir1, 16'hA001);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("ldwait.Pc", 16'(pc1), 16'h0002);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 7'h10, 1'b0);
        chk("ldidle.Pc", 16'(pc1), 16'h0010);

        // Assert reset in the middle of a fetch, which aborts it.
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("abort.Pc", 16'(pc1), 16'h0000);
        chk("abort.Busy", 16'(busy1), 16'h0000);
        id_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (id1 || id3) id_cnt++;
        end
        chk("abort.noId", 16'(id_cnt), 16'd0);

        // Check the timing of the 3-cycle-latency instance.
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        busy_cnt = busy3 ? 1 : 0;
        id_at    = -1;
        for (int k = 1; k < 8; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (busy3) busy_cnt++;
            if (id3 && id_at < 0) begin
                id_at = k;
                chk("lat3.IrData", ir3, 16'hA000);
            end
        end
        chk("lat3.busyCycles", 16'(busy_cnt), 16'd4);
        chk("lat3.idEdge", 16'(id_at), 16'd3);
        chk("lat3.Pc", 16'(pc3), 16'h0001);

        // Apply random stimulus, checked against the model on every cycle.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 AW'($urandom), 1'($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
